// File: rtl/mc_controller_hs.sv
// Multi-cycle RV32 control FSM with a valid/ready memory handshake,
// illegal-opcode trap, bus-timeout error and retired-instruction counter.
module mc_controller_hs #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned EN_JALR  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       aluOP,
  output logic             Branch,
  output logic             PCUpdate,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [3:0]       state_o
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMREAD  = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECR = 4'd6,  EXECI    = 4'd7,
    ALUWB    = 4'd8,  BEQ    = 4'd9,  JAL    = 4'd10, LUI      = 4'd11,
    JALR_ADR = 4'd12, TRAP   = 4'd13, BUSERR = 4'd14
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              mem_access;
  logic              timeout;

  assign state_o    = state;
  assign mem_access = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // A ready in the final wait cycle takes priority over the timeout.
  assign timeout    = (MAX_WAIT != 0) && mem_access && !mem_ready &&
                      (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Next-state and wait counter.
  always_comb begin
    next_state    = FETCH;
    wait_cnt_next = '0;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : (timeout ? BUSERR : FETCH);
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          OP_LUI:       next_state = LUI;
          OP_JALR:      next_state = (EN_JALR != 0) ? JALR_ADR : TRAP;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = mem_ready ? MEMWB : (timeout ? BUSERR : MEMREAD);
      MEMWRITE: next_state = mem_ready ? FETCH : (timeout ? BUSERR : MEMWRITE);
      MEMWB, ALUWB, BEQ:        next_state = FETCH;
      EXECR, EXECI, JAL, LUI:   next_state = ALUWB;
      JALR_ADR: next_state = JAL;
      TRAP:     next_state = TRAP;
      BUSERR:   next_state = BUSERR;
      default:  next_state = FETCH;
    endcase
    // Counts only while the same access keeps waiting; any move clears it.
    if ((MAX_WAIT != 0) && mem_access && !mem_ready && (next_state == state))
      wait_cnt_next = wait_cnt + WAIT_W'(1);
  end

  // Moore decode plus handshake-gated strobes.
  always_comb begin
    mem_req   = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    aluOP     = 2'b00;
    Branch    = 1'b0;
    PCUpdate  = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        IRWrite = mem_ready; PCUpdate = mem_ready;
      end
      DECODE:           begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR, JALR_ADR: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:          begin AdrSrc = 1'b1; mem_req = 1'b1; end
      MEMWRITE:         begin AdrSrc = 1'b1; mem_req = 1'b1; MemWrite = 1'b1; end
      MEMWB:            begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      ALUWB:            RegWrite = 1'b1;
      EXECR:            begin ALUSrcA = 2'b10; aluOP = 2'b10; end
      EXECI:            begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; aluOP = 2'b10; end
      BEQ:              begin ALUSrcA = 2'b10; aluOP = 2'b01; Branch = 1'b1; end
      JAL:              begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCUpdate = 1'b1; end
      LUI:              begin ALUSrcB = 2'b01; aluOP = 2'b11; end
      default: ;
    endcase
    if ((next_state == FETCH) &&
        ((state == ALUWB) || (state == MEMWB) || (state == BEQ) || (state == MEMWRITE)))
      retire = 1'b1;
    if (reset) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCUpdate = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Branch   = 1'b0;
      retire   = 1'b0;
    end
  end

  // State, counters and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      instret    <= '0;
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (retire)               instret    <= instret + CNT_W'(1);
      if (next_state == TRAP)   illegal_op <= 1'b1;
      if (next_state == BUSERR) bus_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs: per-cycle state/control checks and a
// retire scoreboard tracking the instret count.
module tb_mc_controller_hs;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ILL  = 7'b1111111;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR = 4'd6,  S_EXECI = 4'd7,   S_ALUWB = 4'd8;
  localparam logic [3:0] S_BEQ = 4'd9,    S_JAL = 4'd10,    S_LUI = 4'd11;
  localparam logic [3:0] S_JALR = 4'd12,  S_TRAP = 4'd13,   S_BUSERR = 4'd14;

  logic clk, reset;
  logic [6:0] op;
  logic mem_ready, mem_req, AdrSrc, IRWrite, RegWrite, MemWrite, Branch, PCUpdate, retire;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, aluOP;
  logic [3:0] instret, state_o;
  logic illegal_op, bus_err;
  logic [15:0] ctrl;

  logic [6:0] op_b;
  logic ready_b, mem_req_b, AdrSrc_b, IRWrite_b, RegWrite_b, MemWrite_b, Branch_b, PCUpdate_b, retire_b;
  logic [1:0] ALUSrcA_b, ALUSrcB_b, ResultSrc_b, aluOP_b;
  logic [31:0] instret_b;
  logic [3:0] state_b;
  logic illegal_b, bus_err_b;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic [3:0] sb[$];

  mc_controller_hs #(.MAX_WAIT(4), .CNT_W(4), .EN_JALR(1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .mem_req(mem_req),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .aluOP(aluOP),
    .Branch(Branch), .PCUpdate(PCUpdate), .retire(retire), .instret(instret),
    .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o)
  );

  mc_controller_hs #(.MAX_WAIT(0), .CNT_W(32), .EN_JALR(0)) dut_b (
    .clk(clk), .reset(reset), .op(op_b), .mem_ready(ready_b), .mem_req(mem_req_b),
    .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ResultSrc(ResultSrc_b), .AdrSrc(AdrSrc_b),
    .IRWrite(IRWrite_b), .RegWrite(RegWrite_b), .MemWrite(MemWrite_b), .aluOP(aluOP_b),
    .Branch(Branch_b), .PCUpdate(PCUpdate_b), .retire(retire_b), .instret(instret_b),
    .illegal_op(illegal_b), .bus_err(bus_err_b), .state_o(state_b)
  );

  assign ctrl = {mem_req, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
                 RegWrite, MemWrite, aluOP, Branch, PCUpdate, retire};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Expected control word per state from the output table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic r);
    case (st)
      S_FETCH:        return {1'b1, 2'b00, 2'b10, 2'b10, 1'b0, r,    1'b0, 1'b0, 2'b00, 1'b0, r,    1'b0};
      S_DECODE:       return {1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      S_MEMADR,
      S_JALR:         return {1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      S_MEMREAD:      return {1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      S_MEMWRITE:     return {1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, r};
      S_MEMWB:        return {1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
      S_ALUWB:        return {1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
      S_EXECR:        return {1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
      S_EXECI:        return {1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
      S_BEQ:          return {1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
      S_JAL:          return {1'b0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      S_LUI:          return {1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
      default:        return 16'h0000;
    endcase
  endfunction

  // One clock cycle: drive inputs, queue expected instret on retire, check mid-cycle.
  task automatic cyc(input logic [6:0] o, input logic r, input logic [3:0] st);
    logic [15:0] e;
    op = o;
    mem_ready = r;
    e = exp_ctrl(st, r);
    if (e[0]) begin
      exp_cnt = exp_cnt + 4'd1;
      sb.push_back(exp_cnt);
    end
    @(negedge clk);
    chk($sformatf("state@%0d", st), 32'(state_o), 32'(st));
    chk($sformatf("ctrl@%0d", st), 32'(ctrl), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    exp_cnt = 4'd0;
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'(S_FETCH));
    chk("rst_ctrl", 32'(ctrl),
        32'({1'b0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}));
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard: every retire pulse must match a queued instret value one edge later.
  initial begin
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        chk("sb_depth", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk("sb_instret", 32'(instret), 32'(sb.pop_front()));
      end
      if (retire && !reset) pend = 1'b1;
    end
  end

  initial begin
    reset = 1'b0; op = OP_I; mem_ready = 1'b0; op_b = OP_I; ready_b = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // addi, memory always ready
    cyc(OP_I, 1, S_FETCH); cyc(OP_I, 1, S_DECODE); cyc(OP_I, 1, S_EXECI); cyc(OP_I, 1, S_ALUWB);
    chk("instret_addi", 32'(instret), 32'd1);

    // lw with MEMREAD ready delayed three cycles
    cyc(OP_LW, 1, S_FETCH); cyc(OP_LW, 1, S_DECODE); cyc(OP_LW, 1, S_MEMADR);
    cyc(OP_LW, 0, S_MEMREAD); cyc(OP_LW, 0, S_MEMREAD); cyc(OP_LW, 0, S_MEMREAD);
    cyc(OP_LW, 1, S_MEMREAD); cyc(OP_LW, 1, S_MEMWB);

    // sw with fetch ready on the last allowed wait cycle
    cyc(OP_SW, 0, S_FETCH); cyc(OP_SW, 0, S_FETCH); cyc(OP_SW, 0, S_FETCH);
    cyc(OP_SW, 1, S_FETCH); cyc(OP_SW, 1, S_DECODE); cyc(OP_SW, 1, S_MEMADR);
    cyc(OP_SW, 0, S_MEMWRITE); cyc(OP_SW, 0, S_MEMWRITE); cyc(OP_SW, 1, S_MEMWRITE);
    chk("bus_err_late_ready", 32'(bus_err), 32'd0);

    // jalr, r-type, lui
    cyc(OP_JALR, 1, S_FETCH); cyc(OP_JALR, 1, S_DECODE); cyc(OP_JALR, 1, S_JALR);
    cyc(OP_JALR, 1, S_JAL); cyc(OP_JALR, 1, S_ALUWB);
    cyc(OP_R, 1, S_FETCH); cyc(OP_R, 1, S_DECODE); cyc(OP_R, 1, S_EXECR); cyc(OP_R, 1, S_ALUWB);
    cyc(OP_LUI, 1, S_FETCH); cyc(OP_LUI, 1, S_DECODE); cyc(OP_LUI, 1, S_LUI); cyc(OP_LUI, 1, S_ALUWB);
    chk("instret_pre_wrap", 32'(instret), 32'd6);

    // 16 beq: the 4-bit counter wraps back to 6
    for (int i = 0; i < 16; i++) begin
      cyc(OP_BEQ, 1, S_FETCH); cyc(OP_BEQ, 1, S_DECODE); cyc(OP_BEQ, 1, S_BEQ);
    end
    chk("instret_wrap", 32'(instret), 32'd6);

    // reset during a stalled write
    cyc(OP_SW, 1, S_FETCH); cyc(OP_SW, 1, S_DECODE); cyc(OP_SW, 1, S_MEMADR);
    cyc(OP_SW, 0, S_MEMWRITE); cyc(OP_SW, 0, S_MEMWRITE);
    reset = 1'b1;
    #1;
    chk("rst_async_state", 32'(state_o), 32'(S_FETCH));
    chk("rst_async_memwrite", 32'(MemWrite), 32'd0);
    do_reset();

    // fetch never ready: bus error after four wait cycles
    cyc(OP_I, 0, S_FETCH); cyc(OP_I, 0, S_FETCH); cyc(OP_I, 0, S_FETCH); cyc(OP_I, 0, S_FETCH);
    cyc(OP_I, 1, S_BUSERR); cyc(OP_I, 1, S_BUSERR);
    chk("bus_err_set", 32'(bus_err), 32'd1);
    chk("bus_err_no_trap", 32'(illegal_op), 32'd0);
    do_reset();

    // illegal opcode trap
    cyc(OP_ILL, 1, S_FETCH); cyc(OP_ILL, 1, S_DECODE); cyc(OP_ILL, 1, S_TRAP); cyc(OP_ILL, 1, S_TRAP);
    chk("illegal_set", 32'(illegal_op), 32'd1);
    chk("illegal_no_bus_err", 32'(bus_err), 32'd0);

    // second instance: timeout disabled, jalr illegal
    repeat (300) @(posedge clk);
    #1;
    chk("b_no_timeout_state", 32'(state_b), 32'(S_FETCH));
    chk("b_no_timeout_err", 32'(bus_err_b), 32'd0);
    op_b = OP_JALR;
    ready_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b_decode", 32'(state_b), 32'(S_DECODE));
    @(posedge clk);
    #1;
    chk("b_jalr_trap", 32'(state_b), 32'(S_TRAP));
    chk("b_illegal", 32'(illegal_b), 32'd1);
    chk("b_instret", instret_b, 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
